// File: rtl/stopwatch_cu_multi.sv
// Multi-channel stopwatch control FSM: turns run/stop, clear and lap pulses
// into registered run, clear and lap-hold controls per channel.
//
// state | meaning
// ------+----------------------------------------------
// STOP  | counter halted, display live
// RUN   | counter enabled
// CLEAR | counter cleared for CLR_CYCLES cycles
// LAP   | counter enabled, display frozen
module stopwatch_cu_multi #(
    parameter int N_CH       = 2,
    parameter int MODE_W     = 2,
    parameter int SW_MODE    = 0,
    parameter int CLR_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [MODE_W-1:0]   mode,
    input  logic [N_CH-1:0]     i_runstop,
    input  logic [N_CH-1:0]     i_clear,
    input  logic [N_CH-1:0]     i_lap,
    input  logic                i_clear_all,
    output logic [N_CH-1:0]     o_runstop,
    output logic [N_CH-1:0]     o_clear,
    output logic [N_CH-1:0]     o_lap_hold,
    output logic [2*N_CH-1:0]   o_state
);

    localparam int CNT_W = $clog2(CLR_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CLR_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_STOP  = 2'b00,
        ST_RUN   = 2'b01,
        ST_CLEAR = 2'b10,
        ST_LAP   = 2'b11
    } state_t;

    state_t           state_q [N_CH];
    state_t           state_d [N_CH];
    logic [CNT_W-1:0] cnt_q   [N_CH];
    logic [CNT_W-1:0] cnt_d   [N_CH];
    logic             mode_ok;

    assign mode_ok = (mode == MODE_W'(SW_MODE));

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                ST_STOP: begin
                    if (mode_ok) begin
                        if (i_runstop[i]) begin
                            state_d[i] = ST_RUN;
                        end else if (i_clear[i] || i_clear_all) begin
                            state_d[i] = ST_CLEAR;
                            cnt_d[i]   = CNT_LOAD;
                        end
                    end
                end
                ST_RUN: begin
                    if (mode_ok) begin
                        if (i_runstop[i])  state_d[i] = ST_STOP;
                        else if (i_lap[i]) state_d[i] = ST_LAP;
                    end
                end
                ST_LAP: begin
                    if (mode_ok) begin
                        if (i_runstop[i])  state_d[i] = ST_STOP;
                        else if (i_lap[i]) state_d[i] = ST_RUN;
                    end
                end
                ST_CLEAR: begin
                    // a clear in progress finishes regardless of mode
                    if (cnt_q[i] != '0) cnt_d[i]   = cnt_q[i] - 1'b1;
                    else                state_d[i] = ST_STOP;
                end
                default: state_d[i] = ST_STOP;
            endcase
        end
    end

    // outputs decode the next state so they change on the same edge as the state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= ST_STOP;
                cnt_q[i]   <= '0;
            end
            o_runstop  <= '0;
            o_clear    <= '0;
            o_lap_hold <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i]    <= state_d[i];
                cnt_q[i]      <= cnt_d[i];
                o_runstop[i]  <= (state_d[i] == ST_RUN) || (state_d[i] == ST_LAP);
                o_clear[i]    <= (state_d[i] == ST_CLEAR);
                o_lap_hold[i] <= (state_d[i] == ST_LAP);
            end
        end
    end

    always_comb begin
        o_state = '0;
        for (int i = 0; i < N_CH; i++) begin
            o_state[2*i +: 2] = state_q[i];
        end
    end

endmodule

// File: tb/tb_stopwatch_cu_multi.sv
// Self-checking bench for stopwatch_cu_multi: directed scenarios followed by
// random command traffic, all compared against a behavioural channel model.
module tb_stopwatch_cu_multi;

    localparam int N_CH = 2;
    localparam int MODE_W = 2;
    localparam int CLR = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [MODE_W-1:0] mode;
    logic [N_CH-1:0]   i_runstop, i_clear, i_lap;
    logic              i_clear_all;
    logic [N_CH-1:0]   o_runstop, o_clear, o_lap_hold;
    logic [2*N_CH-1:0] o_state;

    stopwatch_cu_multi #(
        .N_CH(N_CH), .MODE_W(MODE_W), .SW_MODE(0), .CLR_CYCLES(CLR)
    ) dut (
        .clk(clk), .rst(rst), .mode(mode),
        .i_runstop(i_runstop), .i_clear(i_clear), .i_lap(i_lap),
        .i_clear_all(i_clear_all),
        .o_runstop(o_runstop), .o_clear(o_clear), .o_lap_hold(o_lap_hold),
        .o_state(o_state)
    );

    always #5 clk = ~clk;

    // model: 0 stopped, 1 running, 2 clearing, 3 lap; left = clear cycles still owed
    int m_st   [N_CH];
    int m_left [N_CH];
    int n_cmp = 0;
    int n_err = 0;

    function automatic void model_reset();
        for (int i = 0; i < N_CH; i++) begin
            m_st[i]   = 0;
            m_left[i] = 0;
        end
    endfunction

    function automatic void model_step(input logic [N_CH-1:0] rs, cl, lp,
                                       input logic ca, input logic [MODE_W-1:0] md);
        for (int i = 0; i < N_CH; i++) begin
            if (m_st[i] == 2) begin
                m_left[i] = m_left[i] - 1;
                if (m_left[i] == 0) m_st[i] = 0;
            end else if (md == 0) begin
                if (rs[i])                            m_st[i] = (m_st[i] == 0) ? 1 : 0;
                else if (lp[i] && m_st[i] != 0)       m_st[i] = (m_st[i] == 1) ? 3 : 1;
                else if ((cl[i] || ca) && m_st[i] == 0) begin
                    m_st[i]   = 2;
                    m_left[i] = CLR;
                end
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [N_CH-1:0]   e_rs, e_cl, e_lh;
        logic [2*N_CH-1:0] e_st;
        for (int i = 0; i < N_CH; i++) begin
            e_rs[i]       = (m_st[i] == 1) || (m_st[i] == 3);
            e_cl[i]       = (m_st[i] == 2);
            e_lh[i]       = (m_st[i] == 3);
            e_st[2*i +: 2] = 2'(m_st[i]);
        end
        chk("runstop", 8'(o_runstop), 8'(e_rs));
        chk("clear", 8'(o_clear), 8'(e_cl));
        chk("lap_hold", 8'(o_lap_hold), 8'(e_lh));
        chk("state", 8'(o_state), 8'(e_st));
    endtask

    task automatic cyc(input logic [N_CH-1:0] rs, cl, lp, input logic ca);
        i_runstop   = rs;
        i_clear     = cl;
        i_lap       = lp;
        i_clear_all = ca;
        @(posedge clk);
        model_step(rs, cl, lp, ca, mode);
        @(negedge clk);
        check_all();
    endtask

    // asynchronous reset mid-cycle, checked before any clock edge
    task automatic async_reset();
        #2 rst = 1'b0;
        model_reset();
        #1;
        chk("areset_outs", 8'({o_runstop, o_clear, o_lap_hold}), 8'h00);
        chk("areset_state", 8'(o_state), 8'h00);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        mode = '0;
        i_runstop = '0; i_clear = '0; i_lap = '0; i_clear_all = 1'b0;
        model_reset();
        #1;
        chk("reset_outs", 8'({o_runstop, o_clear, o_lap_hold}), 8'h00);
        chk("reset_state", 8'(o_state), 8'h00);
        @(negedge clk);
        rst = 1'b1;

        // run / stop on ch0
        cyc(2'b01, 2'b00, 2'b00, 1'b0);
        chk("run_ch0", 8'(o_runstop), 8'h01);
        cyc(2'b01, 2'b00, 2'b00, 1'b0);
        chk("stop_ch0", 8'(o_runstop), 8'h00);

        // ch1 clear lasts CLR cycles; runstop in 2nd cycle ignored
        cyc(2'b00, 2'b10, 2'b00, 1'b0);
        chk("clr_c1", 8'(o_clear), 8'h02);
        cyc(2'b00, 2'b00, 2'b00, 1'b0);
        cyc(2'b10, 2'b00, 2'b00, 1'b0);
        chk("clr_c3", 8'(o_clear), 8'h02);
        cyc(2'b00, 2'b00, 2'b00, 1'b0);
        chk("clr_done", 8'(o_state), 8'h00);

        // lap hold sequence
        cyc(2'b01, 2'b00, 2'b00, 1'b0);
        cyc(2'b00, 2'b00, 2'b01, 1'b0);
        chk("lap_hold", 8'({o_runstop, o_lap_hold}), 8'b0101);
        cyc(2'b00, 2'b00, 2'b01, 1'b0);
        cyc(2'b00, 2'b00, 2'b01, 1'b0);
        cyc(2'b01, 2'b00, 2'b00, 1'b0);
        chk("lap_stop", 8'({o_runstop, o_lap_hold}), 8'h00);

        // simultaneous-pulse priority
        cyc(2'b01, 2'b01, 2'b00, 1'b0);
        chk("prio_rs_clr", 8'({o_runstop, o_clear}), 8'b0100);
        cyc(2'b01, 2'b00, 2'b01, 1'b0);
        chk("prio_rs_lap", 8'(o_state), 8'h00);

        // clear_all only affects stopped channel; mode gating mid-clear
        cyc(2'b01, 2'b00, 2'b00, 1'b0);
        cyc(2'b00, 2'b00, 2'b00, 1'b1);
        chk("clr_all", 8'(o_state), 8'b1001);
        mode = 2'd1;
        cyc(2'b11, 2'b00, 2'b00, 1'b0);
        cyc(2'b11, 2'b00, 2'b00, 1'b0);
        cyc(2'b11, 2'b00, 2'b00, 1'b0);
        chk("gated", 8'(o_state), 8'b0001);
        mode = 2'd0;

        // async reset during CLEAR (ch1) and RUN (ch0)
        cyc(2'b00, 2'b00, 2'b00, 1'b1);
        async_reset();

        // random traffic
        for (int n = 0; n < 400; n++) begin
            logic [N_CH-1:0] rs, cl, lp;
            logic ca;
            mode = ($urandom_range(0, 5) == 0) ? MODE_W'($urandom_range(1, 3)) : '0;
            for (int i = 0; i < N_CH; i++) begin
                rs[i] = ($urandom_range(0, 4) == 0);
                cl[i] = ($urandom_range(0, 3) == 0);
                lp[i] = ($urandom_range(0, 3) == 0);
            end
            ca = ($urandom_range(0, 9) == 0);
            cyc(rs, cl, lp, ca);
            if ($urandom_range(0, 60) == 0) async_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/stopwatch_cu_multi.md
Name: stopwatch_cu_multi

Overview:
Parametrised multi-channel stopwatch control FSM for the UART stopwatch/watch design. Each of N_CH independent channels turns single-cycle run/stop, clear and lap command pulses into registered run, clear and lap-hold controls for its counter datapath. The block responds only while the shared mode bus equals SW_MODE. It also provides a stretchable clear pulse and a global clear-all command.

Parameters:
N_CH, 2, number of independent stopwatch channels (>=1)
MODE_W, 2, width of mode bus
SW_MODE, 0, mode value in which command inputs are accepted
CLR_CYCLES, 1, length of o_clear pulse in clk cycles (>=1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
mode  input  MODE_W  current system mode
i_runstop  input  N_CH  per-channel run/stop command pulse (btn_R or UART)
i_clear  input  N_CH  per-channel clear command pulse (btn_L or UART)
i_lap  input  N_CH  per-channel lap (display hold) command pulse
i_clear_all  input  1  clear every stopped channel
o_runstop  output  N_CH  1 = channel counter enabled
o_clear  output  N_CH  1 = channel counter synchronous clear
o_lap_hold  output  N_CH  1 = freeze channel display while counting continues
o_state  output  2*N_CH  channel i state at [2i+1:2i]

Behaviour:
- Reset (rst=0, async): all channels go to STOP, and all outputs and clear counters are 0. Reset during CLEAR aborts the clear immediately.
- Per-channel states: STOP=00, RUN=01, CLEAR=10, LAP=11.
- Commands are sampled at a rising edge. The state and all outputs update at that same edge, so a pulse at edge k gives new outputs in cycle k+1. Outputs are registered Moore decodes of the new state.
- Output decode:
  - STOP: runstop=0, clear=0, lap_hold=0.
  - RUN: runstop=1, lap_hold=0.
  - LAP: runstop=1, lap_hold=1.
  - CLEAR: runstop=0, clear=1.
- STOP transitions:
  - i_runstop goes to RUN.
  - Otherwise i_clear or i_clear_all goes to CLEAR.
  - i_lap is ignored.
- RUN transitions:
  - i_runstop goes to STOP.
  - Otherwise i_lap goes to LAP.
  - i_clear and i_clear_all are ignored.
- LAP transitions:
  - i_runstop goes to STOP, which releases lap_hold.
  - Otherwise i_lap goes to RUN.
  - Clears are ignored.
- CLEAR: loads a down-counter with CLR_CYCLES-1 on entry. It stays in CLEAR while the counter is nonzero, decrementing each cycle, then goes to STOP. o_clear is high exactly CLR_CYCLES cycles. All commands are ignored during CLEAR.
- Priority for simultaneous pulses on one channel: runstop > lap > clear (clear_all counts as clear).
- Mode gating when mode != SW_MODE:
  - All command inputs are ignored and STOP/RUN/LAP states and outputs hold, so a running channel keeps running.
  - A CLEAR already in progress still counts down and completes to STOP.
- Mode change and command in the same cycle: the command is evaluated against mode sampled at that edge.
- Channels are fully independent. Only i_clear_all and mode are shared.
- Clear counter width is $clog2(CLR_CYCLES+1). The counter never wraps; it saturates at 0 in STOP.
- A command held high for several cycles is treated as a new command each cycle. Pulse shaping is the debouncer's job upstream.

Test Plan:
- Reset, N_CH=2, CLR_CYCLES=3, mode=0: pulse i_runstop[0] -> o_runstop=01, o_state[1:0]=01 in the next cycle. Pulse again -> o_runstop=00, state 00.
- STOP ch1, pulse i_clear[1] -> o_clear[1]=1 for exactly 3 cycles, then state 00. A runstop pulse in the 2nd clear cycle is ignored.
- RUN ch0, pulse i_lap[0] -> o_lap_hold[0]=1 and o_runstop[0]=1. Pulse i_lap -> hold=0. From LAP, pulse i_runstop -> STOP with hold=0.
- Simultaneous i_runstop[0]=1 and i_clear[0]=1 in STOP -> RUN, o_clear[0]=0. In RUN, runstop+lap together -> STOP.
- ch0 RUN, ch1 STOP, pulse i_clear_all -> ch1 CLEAR, ch0 stays RUN. Set mode=1 mid-clear -> clear still completes. Further i_runstop pulses are ignored while mode=1.
- Assert rst=0 asynchronously mid-CLEAR and mid-RUN -> all outputs 0 and states 00 without waiting for a clk edge.
